logicnet_sched: RTL and testbench

Input scheduler and result collector for the registered LogicNet classifier pipeline (512-bit feature vector in, 12-bit class word out, 4 register stages). It packs a narrow valid/ready feature stream into full input vectors and launches each vector into the free-running pipeline. It tags in-flight vectors, captures each result at the exact cycle it emerges, and buffers results in an output FIFO. Credit-based launch control guarantees no result is ever dropped under downstream backpressure.

---
 rtl/logicnet_sched.sv | 143 ++++++++++++++
 tb/tb_logicnet_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/logicnet_sched.sv
// Input scheduler / result collector for the registered LogicNet classifier pipeline.
// Optional perf counters (cnt_launch, cnt_stall, cnt_clr) are built when LOGICNET_SCHED_CNT_EN is defined.
module logicnet_sched #(
  parameter int IN_W       = 64,
  parameter int BEATS      = 8,
  parameter int OUT_W      = 12,
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_last,
  output logic [IN_W*BEATS-1:0] net_in,
  input  logic [OUT_W-1:0]      net_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_W-1:0]      m_data,
  output logic                  busy,
  output logic                  err
`ifdef LOGICNET_SCHED_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [31:0]           cnt_launch,
  output logic [31:0]           cnt_stall
`endif
);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW = $clog2(PIPE_LAT + 2);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = AW + 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t                      state;
  logic [CW-1:0]               beat;
  logic [BEATS-1:0][IN_W-1:0]  asm_buf;
  logic [PIPE_LAT:0]           vld_pipe;
  logic [IW-1:0]               inflight;
  logic [FW-1:0]               fifo_cnt;
  logic [AW-1:0]               wptr, rptr;
  logic [OUT_W-1:0]            mem [FIFO_DEPTH];
  logic                        accept, last_beat, launch, push, pop, full, wr, ovf;

  assign accept    = s_valid & s_ready;
  assign last_beat = (beat == CW'(BEATS - 1));
  // Credit uses only registered counts, so a pop in this cycle cannot enable a launch.
  assign launch    = (state == HOLD) && ((int'(inflight) + int'(fifo_cnt)) < FIFO_DEPTH);

  // Assembly FSM: FILL collects beats, HOLD waits for credit and launches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FILL;
      s_ready <= 1'b0;
      beat    <= '0;
      asm_buf <= '0;
      net_in  <= '0;
      err     <= 1'b0;
    end else begin
      if (ovf || (accept && (last_beat != s_last))) err <= 1'b1;
      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (accept) begin
            asm_buf[beat] <= s_data;
            if (last_beat) begin
              state   <= HOLD;
              s_ready <= 1'b0;
            end else if (s_last) begin
              beat <= '0;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        HOLD: begin
          if (launch) begin
            net_in  <= asm_buf;
            beat    <= '0;
            state   <= FILL;
            s_ready <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Tag ride-along: the top tag marks the cycle net_out holds this vector's result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      inflight <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_LAT-1:0], launch};
      inflight <= inflight + IW'(launch) - IW'(vld_pipe[PIPE_LAT]);
    end
  end

  assign push    = vld_pipe[PIPE_LAT];
  assign m_valid = (fifo_cnt != '0);
  assign pop     = m_valid & m_ready;
  assign full    = (fifo_cnt == FW'(FIFO_DEPTH));
  assign wr      = push & (~full | pop);
  assign ovf     = push & full & ~pop;
  assign m_data  = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= net_out;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      fifo_cnt <= fifo_cnt + FW'(wr) - FW'(pop);
    end
  end

  assign busy = (state == HOLD) | (beat != '0) | (|vld_pipe) | m_valid;

`ifdef LOGICNET_SCHED_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_launch <= '0;
      cnt_stall  <= '0;
    end else if (cnt_clr) begin
      cnt_launch <= '0;
      cnt_stall  <= '0;
    end else begin
      if (launch) cnt_launch <= cnt_launch + 32'd1;
      if ((state == HOLD) && !launch) cnt_stall <= cnt_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logicnet_sched.sv
// Directed bench for logicnet_sched with a 4-stage XOR network model on net_in.
module tb_logicnet_sched;
  localparam int IN_W = 64, BEATS = 8, OUT_W = 12, PIPE_LAT = 4, FIFO_DEPTH = 8;

  logic              clk = 1'b0, rst = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [IN_W-1:0]   s_data = '0;
  logic              s_ready, m_valid, busy, err;
  logic [511:0]      net_in;
  logic [11:0]       net_out, m_data;
`ifdef LOGICNET_SCHED_CNT_EN
  logic              cnt_clr = 1'b0;
  logic [31:0]       cnt_launch, cnt_stall;
`endif

  always #5 clk = ~clk;

  logicnet_sched #(.IN_W(IN_W), .BEATS(BEATS), .OUT_W(OUT_W), .PIPE_LAT(PIPE_LAT),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .net_in(net_in), .net_out(net_out), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .busy(busy), .err(err)
`ifdef LOGICNET_SCHED_CNT_EN
    , .cnt_clr(cnt_clr), .cnt_launch(cnt_launch), .cnt_stall(cnt_stall)
`endif
  );

  // Network model: four register stages of net_in[11:0] ^ net_in[511:500].
  logic [11:0] p1 = '0, p2 = '0, p3 = '0, p4 = '0;
  always @(posedge clk) begin
    p1 <= net_in[11:0] ^ net_in[511:500];
    p2 <= p1;
    p3 <= p2;
    p4 <= p3;
  end
  assign net_out = p4;

  int          n_chk = 0, n_fail = 0, cyc = 0, n_launch = 0, hold_cyc = 0;
  bit          win = 1'b0;
  int          launch_q[$], rt_q[$];
  logic [11:0] res_q[$], exp_q[$];
  logic [511:0] prev_in = '0;

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (net_in !== prev_in && net_in != '0) begin
        n_launch++;
        launch_q.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        res_q.push_back(m_data);
        rt_q.push_back(cyc);
      end
      if (win && !s_ready) hold_cyc++;
    end
    prev_in = net_in;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input int v, input int k);
    return {16'(v * 7 + k), 16'(k), 16'(v), 16'(v * 3 + k + 1)};
  endfunction

  function automatic logic [11:0] exp_of(input int v);
    logic [63:0] b0, b7;
    b0 = beat_data(v, 0);
    b7 = beat_data(v, 7);
    return b0[11:0] ^ b7[63:52];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_wait", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_vec(input int v);
    for (int k = 0; k < BEATS; k++) send_beat(beat_data(v, k), k == BEATS - 1);
    exp_q.push_back(exp_of(v));
  endtask

  task automatic drain(input string tag);
    int n, m;
    n = 0;
    while (res_q.size() < exp_q.size() && n < 400) begin
      tick(1);
      n++;
    end
    tick(10);
    chk({tag, "_count"}, 64'(res_q.size()), 64'(exp_q.size()));
    m = (res_q.size() < exp_q.size()) ? res_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({tag, "_data"}, 64'(res_q[i]), 64'(exp_q[i]));
    res_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int l0, sr;
    // Reset values
    tick(3);
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_net_in", 64'(|net_in), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rel_s_ready0", 64'(s_ready), 64'd0);
    tick(1);
    chk("rel_s_ready1", 64'(s_ready), 64'd1);

    // Single vector: beats 1..8, result 0x001 five cycles after launch
    m_ready = 1'b1;
    launch_q.delete();
    rt_q.delete();
    for (int k = 0; k < BEATS; k++) send_beat(64'(k + 1), k == BEATS - 1);
    exp_q.push_back(12'h001);
    drain("single");
    chk("single_lat", 64'(rt_q[0] - launch_q[0]), 64'd5);
    chk("single_busy", 64'(busy), 64'd0);

    // Back-to-back: 20 vectors, one launch every 9 cycles
    launch_q.delete();
    for (int v = 1; v <= 20; v++) send_vec(v);
    drain("b2b");
    chk("b2b_launches", 64'(launch_q.size()), 64'd20);
    for (int i = 1; i < launch_q.size(); i++)
      chk("b2b_gap", 64'(launch_q[i] - launch_q[i-1]), 64'd9);
    chk("b2b_err", 64'(err), 64'd0);

    // Backpressure: 8 launches max while m_ready=0
    m_ready = 1'b0;
`ifdef LOGICNET_SCHED_CNT_EN
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("clr0_launch", 64'(cnt_launch), 64'd0);
    chk("clr0_stall", 64'(cnt_stall), 64'd0);
`endif
    hold_cyc = 0;
    win = 1'b1;
    l0 = n_launch;
    for (int v = 101; v <= 109; v++) send_vec(v);
    sr = 0;
    repeat (30) begin
      tick(1);
      sr += int'(s_ready);
    end
    chk("bp_s_ready_held", 64'(sr), 64'd0);
    chk("bp_launch8", 64'(n_launch - l0), 64'd8);
    chk("bp_m_valid", 64'(m_valid), 64'd1);
    chk("bp_head", 64'(m_data), 64'(exp_of(101)));
    m_ready = 1'b1;
    for (int v = 110; v <= 112; v++) send_vec(v);
    drain("bp");
    chk("bp_launch12", 64'(n_launch - l0), 64'd12);
    win = 1'b0;
`ifdef LOGICNET_SCHED_CNT_EN
    chk("cnt_launch", 64'(cnt_launch), 64'd12);
    chk("cnt_stall", 64'(cnt_stall), 64'(hold_cyc - 12));
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("clr_launch", 64'(cnt_launch), 64'd0);
    chk("clr_stall", 64'(cnt_stall), 64'd0);
`endif

    // Early s_last on beat 3 drops the partial vector
    for (int k = 0; k < 4; k++) send_beat(beat_data(200, k), k == 3);
    tick(1);
    chk("early_err", 64'(err), 64'd1);
    send_vec(201);
    drain("early");

    // Reset with vectors in flight / buffered
    m_ready = 1'b0;
    for (int v = 301; v <= 303; v++) send_vec(v);
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_s_ready", 64'(s_ready), 64'd0);
    chk("mid_net_in", 64'(|net_in), 64'd0);
    chk("mid_m_valid", 64'(m_valid), 64'd0);
    chk("mid_m_data", 64'(m_data), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_err", 64'(err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    m_ready = 1'b1;
    exp_q.delete();
    res_q.delete();
    tick(20);
    chk("mid_stale", 64'(res_q.size()), 64'd0);
    chk("mid_m_valid2", 64'(m_valid), 64'd0);
    chk("mid_busy2", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
